issue_stage: RTL

Decode/issue stage directly upstream of `register_file`. Accepts 16-bit instructions over a valid/ready handshake, drives the register file read addresses, and tracks pending destination writes in a 16-entry scoreboard. Stalls on RAW/WAW hazards and registers decoded fields plus both operands into a one-entry output stage for execute. Writeback retirements clear scoreboard bits.

---
 rtl/issue_stage_pkg.sv | 80 ++++++++
 rtl/issue_scoreboard.sv | 42 ++++
 rtl/issue_stage.sv | 107 ++++++++++
 3 files changed

// File: rtl/issue_stage_pkg.sv
// issue_stage_pkg
//   Shared definitions for the decode/issue stage: datapath widths,
//   instruction field positions, opcode constants and class masks, the
//   RUN/HALTED state encoding, and a decode helper. The helper maps an
//   instruction word onto its register-file read addresses, the sources it
//   actually uses, and the register it writes.
package issue_stage_pkg;

    localparam int REG_W    = 4;
    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 1 << REG_W;

    // Instruction field positions.
    localparam int OP_MSB = 15;
    localparam int OP_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS_MSB = 7;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 0;

    // Opcodes and opcode classes.
    localparam logic [3:0] OP_LW        = 4'b1000;
    localparam logic [3:0] OP_SW        = 4'b1001;
    localparam logic [3:0] OP_HLT       = 4'b1111;
    localparam logic [3:0] OP_LDB_MASK  = 4'b1110;  // LLB/LHB: 101x
    localparam logic [3:0] OP_LDB_MATCH = 4'b1010;
    localparam logic [3:0] OP_CTL_MASK  = 4'b1100;  // branch/control: 11xx
    localparam logic [3:0] OP_CTL_MATCH = 4'b1100;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [REG_W-1:0] src1;
        logic [REG_W-1:0] src2;
        logic             src1_used;
        logic             src2_used;
        logic             writes;
        logic [REG_W-1:0] rd;
    } decode_t;

    // Unused read ports are parked on rd so the address is always defined;
    // the *_used flags keep those parked reads out of the hazard check.
    function automatic decode_t decode_instr(input logic [DATA_W-1:0] instr);
        decode_t    d;
        logic [3:0] op;
        op          = instr[OP_MSB:OP_LSB];
        d.rd        = instr[RD_MSB:RD_LSB];
        d.src1      = instr[RD_MSB:RD_LSB];
        d.src2      = instr[RD_MSB:RD_LSB];
        d.src1_used = 1'b0;
        d.src2_used = 1'b0;
        d.writes    = 1'b0;
        if (op[3] == 1'b0) begin                        // ALU
            d.src1      = instr[RS_MSB:RS_LSB];
            d.src2      = instr[RT_MSB:RT_LSB];
            d.src1_used = 1'b1;
            d.src2_used = 1'b1;
            d.writes    = 1'b1;
        end else if (op == OP_LW) begin
            d.src1      = instr[RS_MSB:RS_LSB];
            d.src1_used = 1'b1;
            d.writes    = 1'b1;
        end else if (op == OP_SW) begin                 // src2 = rd (store data)
            d.src1      = instr[RS_MSB:RS_LSB];
            d.src1_used = 1'b1;
            d.src2_used = 1'b1;
        end else if ((op & OP_LDB_MASK) == OP_LDB_MATCH) begin
            d.src1_used = 1'b1;                         // read-modify-write of rd
            d.writes    = 1'b1;
        end
        // 11xx control: no sources, no write.
        return d;
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// issue_scoreboard
//   One busy bit per architectural register, marking a destination write
//   that has been issued but not yet retired.
//   Ports:
//     clk, rst          - clock, synchronous active-high reset
//     set_en, set_reg   - mark set_reg busy (instruction issued)
//     clr_en, clr_reg   - mark clr_reg free (writeback retired)
//     busy[15:0]        - registered busy vector
//   A set and a clear on the same register in one cycle leave it busy: the
//   new producer has not written yet, whatever the old one retired.
module issue_scoreboard
    import issue_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en,
    input  logic [REG_W-1:0]    set_reg,
    input  logic                clr_en,
    input  logic [REG_W-1:0]    clr_reg,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_reg] = 1'b1;
        if (clr_en) clr_mask[clr_reg] = 1'b1;
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order of always blocks.
    always_ff @(posedge clk) begin
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
    end

endmodule

// File: rtl/issue_stage.sv
// issue_stage
//   Decode/issue stage feeding execute from a 16 x 16-bit register file.
//   Decodes in_instr, drives the register-file read addresses
//   combinationally, stalls on RAW/WAW hazards against the scoreboard, and
//   captures decoded fields plus both operands into a one-entry output
//   register. Issuing HLT freezes the stage until reset.
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     in_valid/in_ready/in_instr- upstream instruction handshake
//     src_reg1/src_reg2         - register-file read addresses (combinational)
//     src_data1/src_data2       - register-file read data, same cycle
//     out_valid/out_ready       - downstream handshake
//     out_opcode/out_dst_reg/out_writes/out_op1/out_op2/out_imm8
//                               - registered issue payload
//     wb_valid/wb_reg           - writeback retirement, clears busy[wb_reg]
//     busy                      - scoreboard vector
//     halted                    - HLT issued, stage frozen
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_instr,
    output logic [REG_W-1:0]    src_reg1,
    output logic [REG_W-1:0]    src_reg2,
    input  logic [DATA_W-1:0]   src_data1,
    input  logic [DATA_W-1:0]   src_data2,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [3:0]          out_opcode,
    output logic [REG_W-1:0]    out_dst_reg,
    output logic                out_writes,
    output logic [DATA_W-1:0]   out_op1,
    output logic [DATA_W-1:0]   out_op2,
    output logic [7:0]          out_imm8,
    input  logic                wb_valid,
    input  logic [REG_W-1:0]    wb_reg,
    output logic [NUM_REGS-1:0] busy,
    output logic                halted
);

    decode_t dec;
    state_t  state;
    logic    hazard;
    logic    accept;

    assign dec      = decode_instr(in_instr);
    assign src_reg1 = dec.src1;
    assign src_reg2 = dec.src2;

    // Evaluated whether or not in_valid is high, so in_ready reflects the
    // word currently presented. No bypass: a retiring value is read from the
    // register file only after its writeback edge, when busy has dropped.
    assign hazard = (dec.src1_used & busy[dec.src1])
                  | (dec.src2_used & busy[dec.src2])
                  | (dec.writes    & busy[dec.rd]);

    assign halted   = (state == ST_HALTED);
    assign in_ready = !halted && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    issue_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (accept && dec.writes),
        .set_reg (dec.rd),
        .clr_en  (wb_valid),
        .clr_reg (wb_reg),
        .busy    (busy)
    );

    // Output register and run/halt state. The payload only loads on accept,
    // so it stays stable while execute back-pressures.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_dst_reg <= '0;
            out_writes  <= 1'b0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm8    <= '0;
        end else begin
            if (accept) begin
                out_valid   <= 1'b1;
                out_opcode  <= in_instr[OP_MSB:OP_LSB];
                out_dst_reg <= dec.rd;
                out_writes  <= dec.writes;
                out_op1     <= src_data1;
                out_op2     <= src_data2;
                out_imm8    <= in_instr[7:0];
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end

            case (state)
                ST_RUN:    if (accept && in_instr[OP_MSB:OP_LSB] == OP_HLT) state <= ST_HALTED;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= ST_RUN;
            endcase
        end
    end

endmodule
